// File: rtl/stepmotor_ram_arbiter.sv
// stepmotor_ram_arbiter: shares the stepmotor single-port RAM (1-cycle read
// latency) between the CPU data master (port 0) and the step-profile
// sequencer (port 1). At most one access is granted per cycle.
// Build option STEPMOTOR_RAM_ARB_RR_EN: round-robin on contention; when it is
// undefined, port 0 has fixed priority and the `last` register is not built.
module stepmotor_ram_arbiter #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    logic       req0;
    logic       req1;
    logic       blocked;
    logic       gnt0;
    logic       gnt1;
    logic [1:0] rd_pend;

    // Request decode; no grants while in reset or while the RAM requests reset
    always_comb begin
        req0    = m0_read | m0_write;
        req1    = m1_read | m1_write;
        blocked = reset | reset_req;
    end

`ifdef STEPMOTOR_RAM_ARB_RR_EN
    logic last;

    // Round-robin grant: on contention the port that did not win last time wins
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!blocked) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Remember the most recently granted port; reset value lets port 0 win first
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last <= gnt1;
        end
    end
`else
    // Fixed priority grant: port 0 always wins contention
    always_comb begin
        gnt0 = ~blocked & req0;
        gnt1 = ~blocked & req1 & ~req0;
    end
`endif

    // Stall any requester that did not win this cycle
    always_comb begin
        m0_waitrequest = req0 & ~gnt0;
        m1_waitrequest = req1 & ~gnt1;
    end

    // Steer the granted port onto the RAM; address/data are don't-care when idle
    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        ram_write      = 1'b0;
        ram_chipselect = gnt0 | gnt1;
        ram_clken      = ~reset_req;
        if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            ram_write      = m1_write;
        end else if (gnt0) begin
            ram_write      = m0_write;
        end
    end

    // Track which port owns the RAM data returning next cycle (write wins over read)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 2'b00;
        end else begin
            rd_pend <= {gnt1 & m1_read & ~m1_write, gnt0 & m0_read & ~m0_write};
        end
    end

    // Read data is broadcast; the valid flag tells each port whether it is theirs
    always_comb begin
        m0_readdata      = ram_readdata;
        m1_readdata      = ram_readdata;
        m0_readdatavalid = rd_pend[0];
        m1_readdatavalid = rd_pend[1];
    end

endmodule

// File: tb/tb_stepmotor_ram_arbiter.sv
// Directed testbench for stepmotor_ram_arbiter with a behavioural 1-cycle RAM.
module tb_stepmotor_ram_arbiter;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 32;

`ifdef STEPMOTOR_RAM_ARB_RR_EN
    localparam bit          RR_MODE = 1'b1;
    localparam int unsigned CONT_N  = 8;
`else
    localparam bit          RR_MODE = 1'b0;
    localparam int unsigned CONT_N  = 6;
`endif

    localparam logic [31:0] D0    = 32'hCAFE_0000;
    localparam logic [31:0] D100  = 32'hA0A0_0100;
    localparam logic [31:0] D200  = 32'hB1B1_0200;

    logic              clk = 1'b0;
    logic              reset;
    logic              reset_req;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m1_read, m0_write, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] ram_address;
    logic [3:0]        ram_byteenable;
    logic              ram_chipselect, ram_write, ram_clken;
    logic [DATA_W-1:0] ram_writedata;
    logic [DATA_W-1:0] ram_readdata;

    logic [31:0] mem [0:32767];

    int total = 0;
    int bad   = 0;
    int pulses0;
    int pulses1;
    bit g;
    bit pg;

    always #5 clk = ~clk;

    stepmotor_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // Single-port RAM model with registered q; known words are loaded during reset
    always @(posedge clk) begin
        if (reset) begin
            mem[0]       <= D0;
            mem[15'h100] <= D100;
            mem[15'h200] <= D200;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end
            ram_readdata <= mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset_req = 1'b0;
        m0_address = '0; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = 4'hF; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
        ram_readdata = '0;
        step();

        // Reset held: requester stalled, nothing selected, no valids
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("rst_wait0", m0_waitrequest, 1'b1);
            chk1("rst_rdv0", m0_readdatavalid, 1'b0);
            chk1("rst_rdv1", m1_readdatavalid, 1'b0);
            chk1("rst_cs", ram_chipselect, 1'b0);
            step();
        end

        // First cycle after release: m0 read of word 0 accepted immediately
        reset = 1'b0;
        #1;
        chk1("rel_wait0", m0_waitrequest, 1'b0);
        chk1("rel_cs", ram_chipselect, 1'b1);
        chk1("rel_rdv0", m0_readdatavalid, 1'b0);
        step();

        // m0 write DEADBEEF @0x10; read of word 0 returns now
        m0_read = 1'b0; m0_write = 1'b1; m0_address = 15'h0010; m0_writedata = 32'hDEAD_BEEF;
        #1;
        chk1("r0_rdv0", m0_readdatavalid, 1'b1);
        chk("r0_data", m0_readdata, D0);
        chk1("w10_wait0", m0_waitrequest, 1'b0);
        chk1("w10_ramwr", ram_write, 1'b1);
        chk("w10_addr", 32'(ram_address), 32'h10);
        step();

        // m0 read @0x10; the write produced no response
        m0_write = 1'b0; m0_read = 1'b1;
        #1;
        chk1("w10_norsp", m0_readdatavalid, 1'b0);
        chk1("r10_wait0", m0_waitrequest, 1'b0);
        step();

        // m0 write 11223344 @0x7FFF; read @0x10 returns
        m0_read = 1'b0; m0_write = 1'b1; m0_address = 15'h7FFF; m0_writedata = 32'h1122_3344;
        #1;
        chk1("r10_rdv0", m0_readdatavalid, 1'b1);
        chk("r10_data", m0_readdata, 32'hDEAD_BEEF);
        chk1("r10_rdv1", m1_readdatavalid, 1'b0);
        step();

        // Partial write to lane 0 only
        m0_writedata = 32'h0000_00AA; m0_byteenable = 4'h1;
        #1;
        chk("be_lane", 32'(ram_byteenable), 32'h1);
        chk1("be_wait0", m0_waitrequest, 1'b0);
        step();

        // Read back the merged word
        m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'hF;
        #1;
        chk1("r7f_wait0", m0_waitrequest, 1'b0);
        step();

        // m1 alone reads 0x200; merged word returns to m0
        m0_read = 1'b0; m1_read = 1'b1; m1_address = 15'h0200;
        #1;
        chk1("r7f_rdv0", m0_readdatavalid, 1'b1);
        chk("r7f_data", m0_readdata, 32'h1122_33AA);
        chk1("m1_wait1", m1_waitrequest, 1'b0);
        chk("m1_addr", 32'(ram_address), 32'h200);
        step();

        // Idle; m1 data returns to m1 only
        m1_read = 1'b0;
        #1;
        chk1("m1_rdv1", m1_readdatavalid, 1'b1);
        chk1("m1_rdv0", m0_readdatavalid, 1'b0);
        chk("m1_data", m1_readdata, D200);
        chk1("idle_cs", ram_chipselect, 1'b0);
        step();

        // Continuous contention: m0 @0x100, m1 @0x200
        pulses0 = 0; pulses1 = 0; pg = 1'b0;
        m0_read = 1'b1; m0_address = 15'h0100;
        m1_read = 1'b1; m1_address = 15'h0200;
        for (int k = 0; k < int'(CONT_N); k++) begin
            g = RR_MODE && (k % 2 == 1);
            #1;
            chk1("ct_wait0", m0_waitrequest, g);
            chk1("ct_wait1", m1_waitrequest, !g);
            chk("ct_addr", 32'(ram_address), g ? 32'h200 : 32'h100);
            if (k > 0) begin
                chk1("ct_rdv0", m0_readdatavalid, !pg);
                chk1("ct_rdv1", m1_readdatavalid, pg);
                chk("ct_data", m0_readdata, pg ? D200 : D100);
            end
            if (m0_readdatavalid) pulses0++;
            if (m1_readdatavalid) pulses1++;
            pg = g;
            step();
        end
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        chk1("ct_last_rdv0", m0_readdatavalid, !pg);
        chk1("ct_last_rdv1", m1_readdatavalid, pg);
        chk("ct_last_data", m0_readdata, pg ? D200 : D100);
        if (m0_readdatavalid) pulses0++;
        if (m1_readdatavalid) pulses1++;
        chk("ct_pulses0", 32'(pulses0), RR_MODE ? 32'd4 : 32'd6);
        chk("ct_pulses1", 32'(pulses1), RR_MODE ? 32'd4 : 32'd0);
        step();

        // m0 read granted the cycle before reset_req rises
        m0_read = 1'b1; m0_address = 15'h0100;
        #1;
        chk1("pre_rr_wait0", m0_waitrequest, 1'b0);
        step();

        // reset_req high for 4 cycles with both ports requesting
        reset_req = 1'b1; m1_read = 1'b1; m1_address = 15'h0200;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("rr_wait0", m0_waitrequest, 1'b1);
            chk1("rr_wait1", m1_waitrequest, 1'b1);
            chk1("rr_clken", ram_clken, 1'b0);
            chk1("rr_cs", ram_chipselect, 1'b0);
            chk1("rr_rdv0", m0_readdatavalid, i == 0);
            if (i == 0) chk("rr_data", m0_readdata, D100);
            step();
        end

        // reset_req falls: grant resumes immediately (last=0 under round-robin)
        reset_req = 1'b0;
        #1;
        chk1("res_clken", ram_clken, 1'b1);
        chk1("res_wait0", m0_waitrequest, RR_MODE);
        chk1("res_wait1", m1_waitrequest, !RR_MODE);
        step();

        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        chk1("res_rdv0", m0_readdatavalid, !RR_MODE);
        chk1("res_rdv1", m1_readdatavalid, RR_MODE);
        chk("res_data", m0_readdata, RR_MODE ? D200 : D100);
        step();

        // Read accepted, then reset asserted before the edge: the read is dropped
        m0_read = 1'b1; m0_address = 15'h0100;
        #1;
        chk1("mr_wait0", m0_waitrequest, 1'b0);
        reset = 1'b1;
        #1;
        chk1("mr_wait0_rst", m0_waitrequest, 1'b1);
        step();
        reset = 1'b0; m0_read = 1'b0;
        #1;
        chk1("mr_rdv0", m0_readdatavalid, 1'b0);
        chk1("mr_rdv1", m1_readdatavalid, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
